// File: rtl/varset_bank_if.sv
// Avalon-MM slave bundle for the varset register bank.
// Fixed-latency reads, no waitrequest.
interface varset_bank_if #(
    parameter int AW = 9,
    parameter int DW = 32
);
    logic [AW-1:0]   address;
    logic            read;
    logic            write;
    logic [DW-1:0]   writedata;
    logic [DW/8-1:0] byteenable;
    logic [DW-1:0]   readdata;
    logic            readdatavalid;

    modport master (
        output address, read, write,
        output writedata, byteenable,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write,
        input  writedata, byteenable,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/varset_bank.sv
// Staged output registers with atomic commit, and
// snapshot-captured input channels, on an Avalon-MM slave.
module varset_bank #(
    parameter int N_CH = 64,
    parameter int DW   = 32,
    parameter int AW   = 9
) (
    input  logic             clk,
    input  logic             reset,
    varset_bank_if.slave     avs,
    input  logic [N_CH*DW-1:0] i_var,
    input  logic             sync_in,
    output logic [N_CH*DW-1:0] o_reg,
    output logic             o_latch_trigger
);
    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int NB = DW / 8;

    localparam logic [AW-1:0] A_SNAP = AW'(N_CH);
    localparam logic [AW-1:0] A_CTRL = AW'(2 * N_CH);
    localparam logic [AW-1:0] A_STAT = AW'(2 * N_CH + 1);
    localparam logic [AW-1:0] A_CCNT = AW'(2 * N_CH + 2);

    logic [N_CH*DW-1:0] stage_q;
    logic [N_CH*DW-1:0] stage_nxt;
    logic [N_CH*DW-1:0] snap_q;

    logic        auto_commit;
    logic        sync_en;
    logic        pending;
    logic        snap_valid;
    logic [15:0] snap_cnt;
    logic [31:0] commit_cnt;

    logic s1, s2, s3;
    logic sync_rise;

    logic [IW-1:0] idx;
    logic [IW-1:0] sidx;
    logic          wr_stage;
    logic          wr_ctrl;
    logic          do_commit;
    logic          do_snap;
    logic [DW-1:0] rd_mux;

    assign idx  = avs.address[IW-1:0];
    assign sidx = IW'(avs.address - A_SNAP);

    assign wr_stage = avs.write && (avs.address < A_SNAP);
    assign wr_ctrl  = avs.write && (avs.address == A_CTRL)
                      && avs.byteenable[0];

    // An auto-commit publishes the staging image including this write.
    assign do_commit = (wr_ctrl && avs.writedata[0])
                       || (wr_stage && auto_commit);
    assign do_snap   = (wr_ctrl && avs.writedata[1])
                       || (sync_rise && sync_en);

    always_comb begin
        stage_nxt = stage_q;
        if (wr_stage) begin
            for (int b = 0; b < NB; b++) begin
                if (avs.byteenable[b]) begin
                    stage_nxt[idx*DW + b*8 +: 8] =
                        avs.writedata[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        if (avs.address < A_SNAP) begin
            rd_mux = stage_q[idx*DW +: DW];
        end else if (avs.address < A_CTRL) begin
            rd_mux = snap_q[sidx*DW +: DW];
        end else if (avs.address == A_CTRL) begin
            rd_mux = DW'({sync_en, auto_commit, 2'b00});
        end else if (avs.address == A_STAT) begin
            rd_mux = {snap_cnt, 14'd0, snap_valid, pending};
        end else if (avs.address == A_CCNT) begin
            rd_mux = commit_cnt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q           <= '0;
            snap_q            <= '0;
            o_reg             <= '0;
            o_latch_trigger   <= 1'b0;
            auto_commit       <= 1'b0;
            sync_en           <= 1'b0;
            pending           <= 1'b0;
            snap_valid        <= 1'b0;
            snap_cnt          <= '0;
            commit_cnt        <= '0;
            s1                <= 1'b0;
            s2                <= 1'b0;
            s3                <= 1'b0;
            sync_rise         <= 1'b0;
            avs.readdata      <= '0;
            avs.readdatavalid <= 1'b0;
        end else begin
            stage_q <= stage_nxt;

            if (wr_ctrl) begin
                auto_commit <= avs.writedata[2];
                sync_en     <= avs.writedata[3];
            end

            o_latch_trigger <= do_commit;
            if (do_commit) begin
                o_reg      <= stage_nxt;
                commit_cnt <= commit_cnt + 32'd1;
                pending    <= 1'b0;
            end else if (wr_stage) begin
                pending <= 1'b1;
            end

            // Two-flop synchronizer, then a registered rise detect.
            s1        <= sync_in;
            s2        <= s1;
            s3        <= s2;
            sync_rise <= s2 & ~s3;

            if (do_snap) begin
                snap_q     <= i_var;
                snap_valid <= 1'b1;
                snap_cnt   <= snap_cnt + 16'd1;
            end

            avs.readdatavalid <= avs.read;
            if (avs.read) begin
                avs.readdata <= rd_mux;
            end
        end
    end
endmodule
